// File: rtl/mem_pkg.sv
// Shared definitions for the Mini SRC memory responder.
//   - WORD_BITS       : data word width (32)
//   - DEF_ADDR_BITS   : default word-address width (512-word memory)
//   - DEF_WAIT_STATES : default wait states between capture and response
//   - CNT_BITS        : wait counter width (covers 0..15 wait states)
//   - state_e         : responder FSM states
package mem_pkg;

  localparam int unsigned WORD_BITS       = 32;
  localparam int unsigned DEF_ADDR_BITS   = 9;
  localparam int unsigned DEF_WAIT_STATES = 2;
  localparam int unsigned CNT_BITS        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, read-first, registered read, no reset
// on contents.
//   clock : rising-edge clock
//   we    : write enable, writes wdata to addr on the clock edge
//   addr  : word address (read and write share it)
//   wdata : write data
//   rdata : registered read data, mem[addr] as of the previous edge
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned WIDTH     = WORD_BITS
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [0:(1 << ADDR_BITS)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the Mini SRC CPU bus. Captures a Read or Write
// request, waits WAIT_STATES cycles, then completes with a one-cycle MemDone.
// A request with both strobes high is rejected with a one-cycle MemErr.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high; memory contents are kept
//   Read     : read request level, held until MemDone
//   Write    : write request level, held until MemDone
//   Address  : word address, only Address[ADDR_BITS-1:0] used
//   Mdataout : write data from MDR
//   Mdatain  : read data to MDR, held until the next read completes
//   MemDone  : one-cycle completion pulse
//   MemErr   : one-cycle pulse for a simultaneous Read and Write
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Read,
  input  logic                 Write,
  input  logic [WORD_BITS-1:0] Address,
  input  logic [WORD_BITS-1:0] Mdataout,
  output logic [WORD_BITS-1:0] Mdatain,
  output logic                 MemDone,
  output logic                 MemErr
);

  localparam logic [CNT_BITS-1:0] WS_LOAD = CNT_BITS'(WAIT_STATES);

  state_e                 state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [WORD_BITS-1:0]   wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [WORD_BITS-1:0]   mdatain_q;

  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [WORD_BITS-1:0]   mem_rdata;
  logic                   unused_addr;

  assign unused_addr = ^Address[WORD_BITS-1:ADDR_BITS];

  // In IDLE the array is addressed straight from the bus so that with zero
  // wait states the registered read is already valid in the RESP cycle.
  assign mem_addr = (state_q == ST_IDLE) ? Address[ADDR_BITS-1:0] : addr_q;
  // Reset wins over a write sitting in RESP: the write is abandoned.
  assign mem_we   = (state_q == ST_RESP) && wr_q && !reset;

  mem_array #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (WORD_BITS)
  ) u_mem_array (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Read ^ Write) begin
          addr_d  = Address[ADDR_BITS-1:0];
          wdata_d = Mdataout;
          wr_d    = Write;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end else if (Read && Write) begin
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!Read && !Write) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mdatain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if ((state_q == ST_RESP) && !wr_q) begin
        mdatain_q <= mem_rdata;
      end
    end
  end

  // During a read's RESP cycle the array's output register already holds
  // the word; afterwards mdatain_q keeps it. Both sources are registers.
  assign Mdatain = ((state_q == ST_RESP) && !wr_q) ? mem_rdata : mdatain_q;
  assign MemDone = done_q;
  assign MemErr  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (0, 2 and 15 wait
// states) share one request stream; each has its own expected-event queue
// and its own word-level memory model.
module tb_mem_responder;

  typedef struct {
    bit          is_err;
    bit          is_read;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, mdo = '0;
  logic [31:0] mdi [3];
  logic [2:0]  done, err;

  int unsigned cyc = 0;
  int unsigned nchk = 0, nerr = 0;
  bit          mon_on = 1'b0;

  exp_t        sb [3][$];
  logic [31:0] exp_md [3];
  logic [31:0] mdl [3][512];
  logic [8:0]  waddrs [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned ws_of(int i);
    case (i)
      0:       return 0;
      1:       return 2;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_BITS   (9),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 15))
    ) u_dut (
      .clock    (clk),
      .reset    (rst[g]),
      .Read     (rd),
      .Write    (wr),
      .Address  (addr),
      .Mdataout (mdo),
      .Mdatain  (mdi[g]),
      .MemDone  (done[g]),
      .MemErr   (err[g])
    );
  end

  // Monitor: consumes expected events as the DUTs present them.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      for (int i = 0; i < 3; i++) begin
        if (done[i] && err[i]) begin
          nchk <= nchk + 1; nerr <= nerr + 1;
          $display("FAIL done_and_err inst%0d cyc=%0d: both high, want at most one", i, cyc);
        end
        if (done[i] || err[i]) begin
          nchk = nchk + 1;
          if (sb[i].size() == 0) begin
            nerr = nerr + 1;
            $display("FAIL spurious inst%0d cyc=%0d: done=%0b err=%0b, want no event", i, cyc, done[i], err[i]);
          end else begin
            e = sb[i].pop_front();
            if (e.is_err != err[i] || e.cyc != cyc) begin
              nerr = nerr + 1;
              $display("FAIL event inst%0d: got err=%0b at cyc %0d, want err=%0b at cyc %0d",
                       i, err[i], cyc, e.is_err, e.cyc);
            end
            if (!e.is_err && e.is_read) exp_md[i] = e.data;
          end
        end
        if (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
          e = sb[i].pop_front();
          nchk = nchk + 1; nerr = nerr + 1;
          $display("FAIL missing inst%0d: no event by cyc %0d, want err=%0b at cyc %0d", i, cyc, e.is_err, e.cyc);
        end
        nchk = nchk + 1;
        if (mdi[i] !== exp_md[i]) begin
          nerr = nerr + 1;
          $display("FAIL mdatain inst%0d cyc=%0d: got %h want %h", i, cyc, mdi[i], exp_md[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_txn(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int unsigned hold_min);
    int unsigned kcap, n;
    logic [8:0]  ai;
    exp_t        e;
    ai = a[8:0];
    rd = r; wr = w; addr = a; mdo = d;
    kcap = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.is_err  = r && w;
      e.is_read = r && !w;
      e.cyc     = (r && w) ? kcap : kcap + ws_of(i);
      e.data    = e.is_read ? mdl[i][ai] : '0;
      if (w && !r) mdl[i][ai] = d;
      sb[i].push_back(e);
    end
    if (w && !r) waddrs.push_back(ai);
    n = 0;
    do begin
      step();
      n++;
      addr = $urandom;  // post-capture bus changes must be ignored
      mdo  = $urandom;
    end while (!(sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0 && n >= hold_min) && n < 80);
    nchk = nchk + 1;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      nerr = nerr + 1;
      $display("FAIL timeout addr=%h: %0d events outstanding, want 0", a,
               sb[0].size() + sb[1].size() + sb[2].size());
      for (int i = 0; i < 3; i++) sb[i].delete();
    end
    rd = 1'b0; wr = 1'b0;
    step();
    repeat ($urandom_range(0, 2)) step();
  endtask

  initial begin
    int unsigned kcap, op;
    logic [31:0] a;
    exp_t        e;
    for (int i = 0; i < 3; i++) exp_md[i] = '0;
    repeat (3) step();
    rst = '0;
    mon_on = 1'b1;
    repeat (10) step();

    do_txn(1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 0);
    do_txn(1'b1, 1'b0, 32'h0000_0005, '0, 0);
    do_txn(1'b0, 1'b1, 32'h0000_0205, 32'h1234_5678, 0);
    do_txn(1'b1, 1'b0, 32'h0000_0005, '0, 0);
    do_txn(1'b1, 1'b0, 32'h0000_0005, '0, 12);
    do_txn(1'b1, 1'b0, 32'h0000_0005, '0, 0);
    do_txn(1'b1, 1'b1, 32'h0000_0005, 32'hCAFE_F00D, 0);
    do_txn(1'b1, 1'b0, 32'h0000_0005, '0, 0);

    // Mid-transaction reset on the 2- and 15-wait instances only.
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 0);
    rd = 1'b0; wr = 1'b1; addr = 32'h10; mdo = 32'hAAAA_AAAA;
    kcap = cyc + 1;
    e.is_err = 1'b0; e.is_read = 1'b0; e.data = '0; e.cyc = kcap;
    sb[0].push_back(e);
    mdl[0][16] = 32'hAAAA_AAAA;
    step();
    rst = 3'b110; wr = 1'b0;
    step();
    rst = '0; exp_md[1] = '0; exp_md[2] = '0;
    repeat (20) step();
    do_txn(1'b1, 1'b0, 32'h0000_0010, '0, 0);

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 99);
      a  = $urandom & ~32'h1FF;
      if (op < 8) begin
        a[8:0] = 9'($urandom);
        do_txn(1'b1, 1'b1, a, $urandom, 0);
      end else if (op < 55) begin
        a[8:0] = 9'($urandom);
        do_txn(1'b0, 1'b1, a, $urandom, 0);
      end else begin
        a[8:0] = waddrs[$urandom_range(0, waddrs.size() - 1)];
        do_txn(1'b1, 1'b0, a, '0, 0);
      end
    end

    repeat (20) step();
    nchk = nchk + 1;
    if (sb[0].size() + sb[1].size() + sb[2].size() != 0) begin
      nerr = nerr + 1;
      $display("FAIL drain: %0d events outstanding, want 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
